// File: rtl/pipelined_controller.sv
// pipelined_controller
//   Registered decode/control stage sitting between the F/D and X pipeline
//   registers. Decodes the F/D instruction into a 13-bit control word held in
//   the D/X register, raises the F/D stall for load-use hazards and while a
//   multiply/divide is outstanding, inserts bubbles, and drives the multdiv
//   start/ready handshake with an optional timeout.
//
//   Ports
//     clock       in   rising-edge clock
//     reset       in   asynchronous, active-high; clears all state
//     in_valid    in   F/D holds a valid instruction
//     in_insn     in   F/D instruction word
//     flush       in   taken branch/jump in X; kill the F/D instruction
//     md_ready    in   multdiv result valid (only looked at in MD_WAIT)
//     stall_fd    out  hold PC and F/D (combinational)
//     x_valid     out  D/X holds a real instruction
//     x_ctrl      out  D/X control word
//     x_rd        out  D/X destination register
//     md_start    out  one-cycle launch pulse to multdiv
//     md_timeout  out  one-cycle pulse: multdiv wait abandoned
//     illegal     out  D/X holds an undefined opcode
//
//   x_ctrl layout: [0]DMwe [1]Rwe [2]Rwd [3]ReadRd [4]ALUinB [5]j [6]bne
//                  [7]jal [8]jr [9]blt [10]bex [11]setx [12]is_md
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   RUN     | normal flow: decode F/D into D/X every cycle
//   MD_WAIT | mul/div sits in X; D/X held until md_ready or timeout
module pipelined_controller #(
  parameter int INSN_W     = 32,
  parameter int REG_W      = 5,
  parameter int MD_TIMEOUT = 64
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [INSN_W-1:0] in_insn,
  input  logic              flush,
  input  logic              md_ready,
  output logic              stall_fd,
  output logic              x_valid,
  output logic [12:0]       x_ctrl,
  output logic [REG_W-1:0]  x_rd,
  output logic              md_start,
  output logic              md_timeout,
  output logic              illegal
);

  localparam logic [4:0] OP_R    = 5'b00000;
  localparam logic [4:0] OP_J    = 5'b00001;
  localparam logic [4:0] OP_BNE  = 5'b00010;
  localparam logic [4:0] OP_JAL  = 5'b00011;
  localparam logic [4:0] OP_JR   = 5'b00100;
  localparam logic [4:0] OP_ADDI = 5'b00101;
  localparam logic [4:0] OP_BLT  = 5'b00110;
  localparam logic [4:0] OP_SW   = 5'b00111;
  localparam logic [4:0] OP_LW   = 5'b01000;
  localparam logic [4:0] OP_SETX = 5'b10101;
  localparam logic [4:0] OP_BEX  = 5'b10110;

  localparam logic [4:0] ALU_MUL = 5'b00110;
  localparam logic [4:0] ALU_DIV = 5'b00111;

  // The counter only has to hold 0 .. MD_TIMEOUT-1.
  localparam int CNT_W = (MD_TIMEOUT > 1) ? $clog2(MD_TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((MD_TIMEOUT > 0) ? MD_TIMEOUT - 1 : 0);

  typedef enum logic {
    S_RUN,
    S_MD_WAIT
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] md_cnt;

  logic [4:0]       op;
  logic [4:0]       aluop;
  logic [REG_W-1:0] dec_rd;
  logic [REG_W-1:0] dec_rs;
  logic [REG_W-1:0] dec_rt;
  logic [12:0]      dec_ctrl;
  logic             known;
  logic             is_r;
  logic             load_use;
  logic             timeout_hit;
  logic             load_x;
  logic             unused_insn;

  assign op     = in_insn[31:27];
  assign dec_rd = in_insn[26:22];
  assign dec_rs = in_insn[21:17];
  assign dec_rt = in_insn[16:12];
  assign aluop  = in_insn[6:2];

  // shamt and the two low bits play no part in control decode
  assign unused_insn = ^{in_insn[11:7], in_insn[1:0]};

  always_comb begin
    dec_ctrl = '0;
    known    = 1'b1;
    is_r     = 1'b0;
    case (op)
      OP_R: begin
        is_r         = 1'b1;
        dec_ctrl[1]  = 1'b1;
        dec_ctrl[12] = (aluop == ALU_MUL) || (aluop == ALU_DIV);
      end
      OP_J:    dec_ctrl[5] = 1'b1;
      OP_BNE:  begin dec_ctrl[3] = 1'b1; dec_ctrl[6] = 1'b1; end
      OP_JAL:  begin dec_ctrl[1] = 1'b1; dec_ctrl[7] = 1'b1; end
      OP_JR:   begin dec_ctrl[3] = 1'b1; dec_ctrl[8] = 1'b1; end
      OP_ADDI: begin dec_ctrl[1] = 1'b1; dec_ctrl[4] = 1'b1; end
      OP_BLT:  begin dec_ctrl[3] = 1'b1; dec_ctrl[9] = 1'b1; end
      OP_SW:   begin dec_ctrl[0] = 1'b1; dec_ctrl[3] = 1'b1; dec_ctrl[4] = 1'b1; end
      OP_LW:   begin dec_ctrl[1] = 1'b1; dec_ctrl[2] = 1'b1; dec_ctrl[4] = 1'b1; end
      OP_SETX: begin dec_ctrl[1] = 1'b1; dec_ctrl[11] = 1'b1; end
      OP_BEX:  dec_ctrl[10] = 1'b1;
      default: known = 1'b0;
    endcase
  end

  // A load in X whose destination is read by the F/D instruction. The rt
  // field only names a source for R-type; rd is a source for the ReadRd
  // class. Undefined opcodes never raise a hazard.
  assign load_use = x_valid && x_ctrl[2] && (x_rd != '0) && in_valid && known &&
                    ((x_rd == dec_rs) ||
                     (is_r && (x_rd == dec_rt)) ||
                     (dec_ctrl[3] && (x_rd == dec_rd)));

  // Timeout fires in the MD_TIMEOUT-th wait cycle without md_ready; a ready
  // arriving in that same cycle takes precedence.
  assign timeout_hit = (MD_TIMEOUT > 0) && (state == S_MD_WAIT) && !md_ready &&
                       (md_cnt == CNT_LAST);
  assign md_timeout  = timeout_hit;

  always_comb begin
    load_x   = 1'b0;
    stall_fd = 1'b0;
    if (state == S_RUN) begin
      load_x   = !flush && !load_use;
      stall_fd = !flush && load_use;
    end else begin
      // flush is deliberately ignored while the mul/div owns X
      load_x   = md_ready || timeout_hit;
      stall_fd = !load_x;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= S_RUN;
      md_cnt   <= '0;
      x_valid  <= 1'b0;
      x_ctrl   <= '0;
      x_rd     <= '0;
      illegal  <= 1'b0;
      md_start <= 1'b0;
    end else begin
      md_start <= 1'b0;
      if (load_x) begin
        x_valid <= in_valid;
        x_ctrl  <= in_valid ? dec_ctrl : '0;
        x_rd    <= in_valid ? dec_rd : '0;
        illegal <= in_valid && !known;
        md_cnt  <= '0;
        if (in_valid && dec_ctrl[12]) begin
          state    <= S_MD_WAIT;
          md_start <= 1'b1;
        end else begin
          state <= S_RUN;
        end
      end else if (state == S_RUN) begin
        x_valid <= 1'b0;
        x_ctrl  <= '0;
        x_rd    <= '0;
        illegal <= 1'b0;
        md_cnt  <= '0;
      end else if (MD_TIMEOUT > 0) begin
        md_cnt <= md_cnt + CNT_W'(1);
      end
    end
  end

endmodule
